// File: rtl/nor_reduce_pipe.sv
// Pipelined WIDTH-bit NOR/OR reduction built from a FANIN-ary registered OR tree,
// with a global-stall valid/ready handshake and a saturating count of asserted results.
module nor_reduce_pipe #(
   parameter int WIDTH = 128,
   parameter int FANIN = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_y,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] hit_cnt
);

   function automatic int calc_stages(int w, int f);
      int st;
      int p;
      st = 1;
      p  = f;
      while (p < w) begin
         p  = p * f;
         st = st + 1;
      end
      return st;
   endfunction

   function automatic int ipow(int b, int e);
      int r;
      r = 1;
      for (int i = 0; i < e; i++) r = r * b;
      return r;
   endfunction

   localparam int STAGES = calc_stages(WIDTH, FANIN);
   localparam int PAD_W  = ipow(FANIN, STAGES);

   logic             advance;
   logic [PAD_W-1:0] pad_data;

   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // Idle cycles feed zeros so bubbles never carry stale or unknown data.
   assign pad_data = in_valid ? PAD_W'(in_data) : '0;

   for (genvar s = 1; s <= STAGES; s++) begin : g_st
      localparam int IW = ipow(FANIN, STAGES - s + 1);
      localparam int OW = IW / FANIN;

      logic [IW-1:0] src;
      logic          src_v;
      logic          src_m;
      logic [OW-1:0] red;
      logic [OW-1:0] nxt;
      logic [OW-1:0] data_q;
      logic          valid_q;

      if (s == 1) begin : g_head
         assign src   = pad_data;
         assign src_v = in_valid & advance;
         assign src_m = in_valid & in_mode;
      end else begin : g_link
         assign src   = g_st[s-1].data_q;
         assign src_v = g_st[s-1].valid_q;
         assign src_m = g_st[s-1].g_mode.mode_q;
      end

      // The last stage applies the mode; an empty slot there reads as 0.
      always_comb begin
         red = '0;
         for (int i = 0; i < OW; i++) red[i] = |src[i*FANIN +: FANIN];
         nxt = red;
         if (s == STAGES) nxt = src_v ? (src_m ? red : ~red) : '0;
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
         end else if (advance) begin
            valid_q <= src_v;
            data_q  <= nxt;
         end
      end

      if (s < STAGES) begin : g_mode
         logic mode_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)       mode_q <= 1'b0;
            else if (advance) mode_q <= src_m;
         end
      end
   end

   assign out_valid = g_st[STAGES].valid_q;
   assign out_y     = g_st[STAGES].data_q[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hit_cnt <= '0;
      else if (cnt_clr)
         hit_cnt <= '0;
      else if (out_valid & out_ready & out_y & (hit_cnt != {CNT_W{1'b1}}))
         hit_cnt <= hit_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_nor_reduce_pipe.sv
// Directed bench for nor_reduce_pipe: a queue-based result model checked every cycle,
// plus literal expectations for latency, sequences, counter edges, reset and small widths.
module tb_nor_reduce_pipe;
   localparam int W  = 128;
   localparam int F  = 4;
   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          in_valid, in_ready, in_mode, out_valid, out_ready, out_y, cnt_clr;
   logic [W-1:0]  in_data;
   logic [CW-1:0] hit_cnt;

   logic       a_valid, a_ready, a_mode, a_ovalid, a_oready, a_y, a_clr;
   logic [0:0] a_data;
   logic [7:0] a_cnt;
   logic       b_valid, b_ready, b_mode, b_ovalid, b_oready, b_y, b_clr;
   logic [4:0] b_data;
   logic [7:0] b_cnt;

   nor_reduce_pipe #(.WIDTH(W), .FANIN(F), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
      .cnt_clr(cnt_clr), .hit_cnt(hit_cnt));

   nor_reduce_pipe #(.WIDTH(1), .FANIN(4), .CNT_W(8)) dut_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
      .in_mode(a_mode), .out_valid(a_ovalid), .out_ready(a_oready), .out_y(a_y),
      .cnt_clr(a_clr), .hit_cnt(a_cnt));

   nor_reduce_pipe #(.WIDTH(5), .FANIN(4), .CNT_W(8)) dut_w5 (
      .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
      .in_mode(b_mode), .out_valid(b_ovalid), .out_ready(b_oready), .out_y(b_y),
      .cnt_clr(b_clr), .hit_cnt(b_cnt));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_y(input logic [W-1:0] d, input logic m);
      return m ? (d != '0) : (d == '0);
   endfunction

   // Reference model: expected results in acceptance order and a saturating hit count.
   bit exp_q[$];
   bit obs_q[$];
   int obs_t[$];
   int m_hits = 0;
   int cyc = 0;
   bit prev_stall = 0;
   bit prev_y = 0;

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         check("hit_cnt", hit_cnt, m_hits);
         if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_y", out_y, prev_y);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL stale_out: got out_valid=1, expected no result pending (t=%0t)", $time);
            end else begin
               check("out_y", out_y, exp_q[0]);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_y     = out_y;
         if (cnt_clr)
            m_hits = 0;
         else if (out_valid && out_ready && exp_q.size() > 0 && exp_q[0] && m_hits < (1 << CW) - 1)
            m_hits++;
         if (out_valid && out_ready) begin
            obs_q.push_back(out_y);
            obs_t.push_back(cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
         end
         if (in_valid && in_ready) exp_q.push_back(ref_y(in_data, in_mode));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic m);
      logic acc;
      bit   done;
      done     = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
         if (acc) done = 1;
      end
      in_valid = 1'b0;
      in_data  = '0;
      in_mode  = 1'b0;
      if (!done) check("send_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      bit done;
      done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         tick();
         if (exp_q.size() == 0 && !out_valid) done = 1;
      end
      if (!done) check("drain_timeout", 0, 1);
   endtask

   function automatic logic [15:0] pack_obs();
      logic [15:0] v;
      v = '0;
      for (int i = 0; i < obs_q.size() && i < 16; i++) v[i] = obs_q[i];
      return v;
   endfunction

   logic [W-1:0] one;
   int           cnt_a, cnt_b;
   bit           ea, eb, seen;

   initial begin
      one = '0;
      one[0] = 1'b1;
      in_valid = 0; in_data = '0; in_mode = 0; out_ready = 1; cnt_clr = 0;
      a_valid = 0; a_data = '0; a_mode = 0; a_oready = 1; a_clr = 0;
      b_valid = 0; b_data = '0; b_mode = 0; b_oready = 1; b_clr = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_y", out_y, 0);
      check("rst_hit_cnt", hit_cnt, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      tick();

      // Basic NOR: accepted at edge 0, valid after edge 3, counted after edge 4.
      in_valid = 1; in_data = '0; in_mode = 0;
      @(posedge clk);
      #1 in_valid = 0;
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("basic_latency", out_valid, (k == 3) ? 1 : 0);
      end
      check("basic_y", out_y, 1);
      tick();
      check("basic_hit", hit_cnt, 1);

      // Single set bit at 0, 63, 127 in both modes.
      obs_q.delete();
      for (int m = 0; m < 2; m++) begin
         send(one, m[0]);
         send(one << 63, m[0]);
         send(one << 127, m[0]);
      end
      wait_drain();
      check("walk_count", obs_q.size(), 6);
      check("walk_seq", pack_obs(), 16'b111000);
      check("walk_hits", hit_cnt, 4);

      // Back-to-back mode mix.
      obs_q.delete();
      obs_t.delete();
      send('0, 0);
      send('0, 1);
      send(one, 0);
      send(one, 1);
      wait_drain();
      check("mix_count", obs_q.size(), 4);
      check("mix_seq", pack_obs(), 16'b1001);
      if (obs_t.size() == 4) check("mix_consecutive", obs_t[3] - obs_t[0], 3);
      check("mix_hits", hit_cnt, 6);

      // Backpressure: stall output for 5 cycles after first result.
      obs_q.delete();
      fork
         begin
            send('0, 0);
            send(W'(5), 0);
            send('0, 1);
            send(one << 100, 1);
            send('0, 0);
            send('1, 1);
         end
         begin
            seen = 0;
            for (int k = 0; k < 30 && !seen; k++) begin
               tick();
               if (out_valid) seen = 1;
            end
            if (!seen) check("bp_first_timeout", 0, 1);
            out_ready = 0;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("bp_in_ready", in_ready, 0);
               tick();
            end
            out_ready = 1;
         end
      join
      wait_drain();
      check("bp_count", obs_q.size(), 6);
      check("bp_seq", pack_obs(), 16'b111001);
      check("bp_hits", hit_cnt, 10);

      // Counter saturation and clear-over-increment.
      cnt_clr = 1;
      tick();
      cnt_clr = 0;
      check("clr_hits", hit_cnt, 0);
      for (int k = 0; k < 16; k++) send('0, 0);
      wait_drain();
      check("sat_hits", hit_cnt, 15);
      send('0, 0);
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         if (out_valid) seen = 1;
         else tick();
      end
      if (!seen) check("clrhit_timeout", 0, 1);
      cnt_clr = 1;
      tick();
      cnt_clr = 0;
      check("clr_priority", hit_cnt, 0);
      wait_drain();

      // Reset mid-flight.
      send('0, 0);
      wait_drain();
      check("pre_rst_hits", hit_cnt, 1);
      send('0, 0);
      send('0, 1);
      send('0, 0);
      tick();
      check("pre_rst_valid", out_valid, 1);
      #1 rst_n = 0;
      #1;
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_hits", hit_cnt, 0);
      exp_q.delete();
      m_hits = 0;
      prev_stall = 0;
      #1 rst_n = 1;
      repeat (10) tick();
      check("post_rst_valid", out_valid, 0);
      check("post_rst_hits", hit_cnt, 0);

      // WIDTH=1 (one stage) and WIDTH=5 (two stages), all inputs and both modes.
      cnt_a = 0;
      cnt_b = 0;
      check("w1_ready", a_ready, 1);
      check("w5_ready", b_ready, 1);
      for (int v = 0; v < 32; v++) begin
         for (int m = 0; m < 2; m++) begin
            ea = m[0] ? (v[0] != 1'b0) : (v[0] == 1'b0);
            eb = m[0] ? (v != 0) : (v == 0);
            cnt_a += ea;
            cnt_b += eb;
            a_valid = 1; a_data = v[0:0]; a_mode = m[0];
            b_valid = 1; b_data = v[4:0]; b_mode = m[0];
            @(posedge clk);
            #1;
            a_valid = 0; b_valid = 0;
            @(negedge clk);
            check("w1_valid", a_ovalid, 1);
            check("w1_y", a_y, ea);
            check("w5_early", b_ovalid, 0);
            @(posedge clk);
            @(negedge clk);
            check("w5_valid", b_ovalid, 1);
            check("w5_y", b_y, eb);
            tick();
         end
      end
      check("w1_hits", a_cnt, cnt_a);
      check("w5_hits", b_cnt, cnt_b);
      check("w1_hits_lit", a_cnt, 32);
      check("w5_hits_lit", b_cnt, 32);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, expected finish before 300000");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/nor_reduce_pipe.md
Name: nor_reduce_pipe

Overview:
- Parametrised, pipelined successor to the two-input NOR cell.
- Reduces a WIDTH-bit operand to one bit: NOR (all-zero detect) or OR (any-one detect), selected per transaction.
- Uses a FANIN-ary registered tree with valid/ready flow control, so wide zero checks on the AES datapath (state words, round keys, 128-bit compare results) close timing.
- Keeps a saturating count of asserted results for status and debug.

Parameters:
- WIDTH, 128, operand width in bits (>=1).
- FANIN, 4, inputs per reduction node per stage (>=2).
- CNT_W, 16, width of the hit counter.
- STAGES, derived, ceil(log_FANIN(WIDTH)), minimum 1; pipeline depth. Not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- in_mode  input  1  0 = NOR (result 1 iff in_data == 0); 1 = OR (result 1 iff in_data != 0).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_y  output  1  reduction result.
- cnt_clr  input  1  synchronous clear of hit_cnt.
- hit_cnt  output  CNT_W  number of accepted results with out_y == 1, saturating.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits, stage data and stage mode bits clear to 0.
  - out_valid = 0, out_y = 0, hit_cnt = 0, in_ready = 1 (combinational, see below).
  - Reset mid-operation discards all in-flight operands. No output is produced for them.
- Reduction:
  - Stage s ORs groups of FANIN bits from stage s-1 and registers the results.
  - Operand width is zero-padded up to FANIN^STAGES. Zero is the OR identity, so padding never changes the result.
  - in_mode is registered alongside the data at every stage.
  - Final stage: out_y = mode ? or_result : ~or_result. Inversion happens only at the last stage.
- Handshake:
  - Global stall: advance = ~out_valid | out_ready; in_ready = advance.
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - When advance = 1, every stage loads from its predecessor, stage valid bits included. Stage 1 valid loads in_valid & in_ready.
  - When advance = 0, every stage holds. out_y and out_valid stay stable until the output transfer.
  - Bubbles are not compacted. A bubble occupies a stage slot.
- Latency:
  - An operand accepted at edge t appears with out_valid = 1 after edge t+STAGES-1, i.e. on the cycle following edge t+STAGES-1. This assumes no stalls.
  - Throughput is one operand per cycle while out_ready = 1.
  - WIDTH = 1 gives STAGES = 1: a single registered inversion or pass-through.
- Ordering: results leave in acceptance order. in_mode for each operand travels with it; mode changes between back-to-back operands are legal.
- Simultaneous events:
  - With out_valid & out_ready, a new input transfer in the same cycle is allowed and the pipe shifts normally.
- Hit counter:
  - On an output transfer with out_y = 1, hit_cnt increments by 1.
  - hit_cnt saturates at 2^CNT_W-1 and holds there.
  - cnt_clr = 1 sets hit_cnt to 0 at the next edge. It has priority over a coincident increment, so the result is 0, not 1.
  - cnt_clr has no effect on pipeline contents.
- No X propagation: in_data and in_mode are ignored when in_valid is 0. Stage data registers then load 0.

Test Plan:
- Basic NOR, WIDTH=128, FANIN=4, out_ready=1: in_data=0, in_mode=0 at edge 0 -> out_valid=1 with out_y=1 on the cycle after edge 3. hit_cnt=1 after the transfer.
- Single-bit sensitivity: walk a lone 1 through bit positions 0, 63, 127 with in_mode=0 -> out_y=0 each time. The same operands with in_mode=1 -> out_y=1.
- Back-to-back mixed modes: {0/mode0, 0/mode1, 1/mode0, 1/mode1} on consecutive cycles -> out_y sequence 1, 0, 0, 1 on four consecutive cycles. hit_cnt=2.
- Backpressure: stream 6 operands; hold out_ready=0 for 5 cycles after the first result:
  - in_ready=0 throughout the stall.
  - out_y held stable during the stall.
  - No loss or duplication: exactly 6 transfers in order.
- Counter edges, CNT_W=4:
  - 16 hits -> hit_cnt=15 (saturated).
  - cnt_clr asserted in the same cycle as a hit transfer -> hit_cnt=0.
- Reset mid-flight: accept 3 operands, pulse rst_n low between edges -> out_valid=0 and hit_cnt=0 immediately, no stale results afterwards. Then WIDTH=1 and WIDTH=5 (FANIN=4, STAGES=2) builds give correct results for all inputs.
